dram_unaligned_port: RTL
========================

// Module: dram_unaligned_port
// PURPOSE
//  Parametrised CPU-side port in front of the SDRAM MemoryController: accepts byte..word loads/stores
//  at any byte address, splits accesses crossing a word boundary into two aligned transactions,
//  merges/extends read data and schedules refreshes. Generalised in word width, size encoding and
//  refresh policy; adds queued refresh requests and split-access statistics.
// PARAMETERS
//  DATA_BYTES   4     bytes per memory word; power of two, 2..16; OFFW=log2(DATA_BYTES)
//  ADDR_W       32    byte-address width
//  SZW          2     width of size field; size code s means 2**s bytes, s<=OFFW
//  REF_INTERVAL 1000  accepted accesses between automatic refreshes
//  REF_EN       1     0 removes automatic and commanded refresh (i_refresh_cmd ignored)
// PORTS
//  clk            in   1              system clock
//  rst_x          in   1              asynchronous active-low reset
//  i_rd_en        in   1              load request, sampled in IDLE
//  i_wr_en        in   1              store request, sampled in IDLE; i_rd_en wins if both
//  i_addr         in   ADDR_W         byte address
//  i_data         in   8*DATA_BYTES   store data, right-aligned
//  i_ctrl         in   SZW+1          [SZW-1:0] size code, [SZW] 1=zero-extend load
//  o_data         out  8*DATA_BYTES   load data, right-aligned, extended
//  o_busy         out  1              port busy
//  i_refresh_en   in   1              automatic refresh permitted (system init done)
//  i_refresh_cmd  in   1              one-cycle explicit refresh request
//  o_split_cnt    out  32             number of accesses split into two transactions (wraps)
//  o_mem_rd/wr    out  1 each         controller read/write strobes
//  o_mem_refresh  out  1              controller refresh strobe
//  o_mem_addr     out  ADDR_W         aligned word address (low OFFW bits zero)
//  o_mem_wdata    out  8*DATA_BYTES   write data, lane-positioned
//  o_mem_mask_n   out  DATA_BYTES     active-low byte mask (0 = write lane)
//  i_mem_rdata    in   8*DATA_BYTES   controller read data, valid when i_mem_busy falls
//  i_mem_busy     in   1              controller busy
// BEHAVIOUR
//  Reset: all outputs 0 except o_mem_mask_n = all ones; state IDLE, counters 0, pending refresh clear.
//  o_busy = stall_reg | i_mem_busy; stall_reg set the cycle after acceptance, cleared in DONE.
//  Accept only in IDLE with !i_mem_busy; latch addr, ctrl, data. size code >OFFW is clamped to OFFW.
//  off=addr[OFFW-1:0], n=2**size; split when off+n > DATA_BYTES; o_split_cnt++ on accepted split.
//  States: IDLE, ISSUE1, WAIT1, ISSUE2, WAIT2, REF_ISSUE, REF_WAIT, DONE.
//  ISSUE*: strobe high until first cycle i_mem_busy=1, then strobe low -> WAIT*; WAIT*: on
//   i_mem_busy=0 capture word (reads) -> ISSUE2 if split and first half, else DONE.
//  Second transaction address = first + DATA_BYTES, wraps modulo 2**ADDR_W.
//  Read: o_data = extend(({w2,w1} >> 8*off)[8n-1:0]); sign bit = bit 8n-1 unless i_ctrl[SZW];
//   w2 = 0 if not split. o_data stable from DONE until next acceptance.
//  Write: be = ((1<<n)-1) << off over 2*DATA_BYTES lanes; wd = data << 8*off over 2 words;
//   first txn uses low halves, second high halves; o_mem_mask_n = ~be half.
//  DONE: one cycle, clears stall -> IDLE. Aligned access latency: accept + issue/wait + 1.
//  Refresh: pending flag set by i_refresh_cmd (any state) or by count>=REF_INTERVAL with
//   i_refresh_en; count increments per accepted access, clears on refresh start. In IDLE a
//   request has priority over pending refresh; refresh taken only with no rd/wr and !i_mem_busy.
//   REF_ISSUE/REF_WAIT use same strobe handshake, then DONE. Two cmds while pending merge.
//  Reset mid-operation: strobes drop immediately, transaction abandoned, no partial retry.
// TESTING
//  LW addr 0x100, mem[0x100]=0x11223344 -> one read, o_data=0x11223344, o_split_cnt=0.
//  LW addr 0x103, mem[0x100]=0x44332211, mem[0x104]=0x88776655 -> reads 0x100,0x104, o_data=0x77665544.
//  LH signed addr 0x103 bytes 0x80@0x103,0x01@0x104 -> o_data=0x00000180; LB 0x103 -> 0xFFFFFF80, LBU -> 0x80.
//  SW 0xAABBCCDD addr 0x101 -> txn1 mask_n 0001 wdata 0xBBCCDD00, txn2 addr 0x104 mask_n 1110 wdata 0xAA.
//  i_refresh_cmd together with i_rd_en -> read completes first, then one o_mem_refresh handshake.
//  REF_INTERVAL=4, i_refresh_en=1, 4 loads -> refresh after 4th; rst_x low in WAIT2 -> outputs reset.

Source files
------------

// File: rtl/dram_unaligned_port_if.sv
// dram_unaligned_port_if: CPU request/response signals and SDRAM controller signals of dram_unaligned_port.
// slave modport is the port's own view (CPU requests and controller status in, strobes/data out);
// master modport is the environment's view (CPU plus controller) driving the other side.
interface dram_unaligned_port_if #(
    parameter int DATA_BYTES = 4,
    parameter int ADDR_W     = 32,
    parameter int SZW        = 2
);
    localparam int DW = 8 * DATA_BYTES;
    logic                  i_rd_en;
    logic                  i_wr_en;
    logic [ADDR_W-1:0]     i_addr;
    logic [DW-1:0]         i_data;
    logic [SZW:0]          i_ctrl;
    logic [DW-1:0]         o_data;
    logic                  o_busy;
    logic                  i_refresh_en;
    logic                  i_refresh_cmd;
    logic [31:0]           o_split_cnt;
    logic                  o_mem_rd;
    logic                  o_mem_wr;
    logic                  o_mem_refresh;
    logic [ADDR_W-1:0]     o_mem_addr;
    logic [DW-1:0]         o_mem_wdata;
    logic [DATA_BYTES-1:0] o_mem_mask_n;
    logic [DW-1:0]         i_mem_rdata;
    logic                  i_mem_busy;
    modport slave (
        input  i_rd_en, i_wr_en, i_addr, i_data, i_ctrl, i_refresh_en, i_refresh_cmd, i_mem_rdata, i_mem_busy,
        output o_data, o_busy, o_split_cnt, o_mem_rd, o_mem_wr, o_mem_refresh, o_mem_addr, o_mem_wdata, o_mem_mask_n
    );
    modport master (
        output i_rd_en, i_wr_en, i_addr, i_data, i_ctrl, i_refresh_en, i_refresh_cmd, i_mem_rdata, i_mem_busy,
        input  o_data, o_busy, o_split_cnt, o_mem_rd, o_mem_wr, o_mem_refresh, o_mem_addr, o_mem_wdata, o_mem_mask_n
    );
endinterface

// File: rtl/dram_unaligned_port.sv
// dram_unaligned_port: CPU-side SDRAM port doing unaligned byte..word loads/stores, access splitting and refresh scheduling.
// Ports: clk, rst_x (async active-low), bus (dram_unaligned_port_if.slave: CPU request/response and controller strobes).
module dram_unaligned_port #(
    parameter int DATA_BYTES   = 4,
    parameter int ADDR_W       = 32,
    parameter int SZW          = 2,
    parameter int REF_INTERVAL = 1000,
    parameter int REF_EN       = 1
) (
    input logic clk,
    input logic rst_x,
    dram_unaligned_port_if.slave bus
);
    localparam int OFFW = $clog2(DATA_BYTES);
    localparam int DW   = 8 * DATA_BYTES;
    localparam logic [SZW-1:0] MAX_SZ = SZW'(OFFW);
    typedef enum logic [2:0] {IDLE, ISSUE1, WAIT1, ISSUE2, WAIT2, REF_ISSUE, REF_WAIT, DONE} state_t;
    state_t state, state_n;
    logic stall, rd_q, split_q, zext_q, ref_pend;
    logic [ADDR_W-1:0] addr_q, word_addr;
    logic [SZW-1:0] size_q, size_c;
    logic [DW-1:0] data_q, w1_q;
    logic [31:0] ref_cnt;
    logic [OFFW-1:0] off;
    logic accept, ref_go, split_c, first, second, sign;
    logic [2*DATA_BYTES-1:0] be2;
    logic [2*DW-1:0] wd2, rd_words, shifted, lmask, ext;
    assign off       = addr_q[OFFW-1:0];
    assign word_addr = {addr_q[ADDR_W-1:OFFW], {OFFW{1'b0}}};
    assign size_c    = (bus.i_ctrl[SZW-1:0] > MAX_SZ) ? MAX_SZ : bus.i_ctrl[SZW-1:0];
    assign split_c   = (int'(bus.i_addr[OFFW-1:0]) + (1 << size_c)) > DATA_BYTES;
    assign accept    = state == IDLE && !bus.i_mem_busy && (bus.i_rd_en || bus.i_wr_en);
    assign ref_go    = REF_EN != 0 && state == IDLE && !bus.i_mem_busy && !bus.i_rd_en && !bus.i_wr_en && ref_pend;
    assign first     = state == ISSUE1 || state == WAIT1;
    assign second    = state == ISSUE2 || state == WAIT2;
    // Byte enables and store data laid out over two consecutive words; each transaction takes one half.
    assign be2 = ~({(2*DATA_BYTES){1'b1}} << (1 << size_q)) << off;
    assign wd2 = {{DW{1'b0}}, data_q} << {off, 3'b000};
    // Load extraction: {w2,w1} with w2 zero for unsplit loads, shifted down to the byte offset, then extended.
    assign rd_words = (state == WAIT2) ? {bus.i_mem_rdata, w1_q} : {{DW{1'b0}}, bus.i_mem_rdata};
    assign shifted  = rd_words >> {off, 3'b000};
    assign lmask    = ~({(2*DW){1'b1}} << (8 << size_q));
    assign sign     = |(shifted & lmask & ~(lmask >> 1));
    assign ext      = (shifted & lmask) | ((sign && !zext_q) ? ~lmask : '0);
    assign bus.o_busy = stall | bus.i_mem_busy;
    always_ff @(posedge clk or negedge rst_x)
        if (!rst_x) state <= IDLE;
        else state <= state_n;
    always_comb begin
        state_n = state;
        case (state)
            IDLE:      state_n = accept ? ISSUE1 : ref_go ? REF_ISSUE : IDLE;
            ISSUE1:    state_n = bus.i_mem_busy ? WAIT1 : ISSUE1;
            WAIT1:     state_n = bus.i_mem_busy ? WAIT1 : split_q ? ISSUE2 : DONE;
            ISSUE2:    state_n = bus.i_mem_busy ? WAIT2 : ISSUE2;
            WAIT2:     state_n = bus.i_mem_busy ? WAIT2 : DONE;
            REF_ISSUE: state_n = bus.i_mem_busy ? REF_WAIT : REF_ISSUE;
            REF_WAIT:  state_n = bus.i_mem_busy ? REF_WAIT : DONE;
            default:   state_n = IDLE;
        endcase
        bus.o_mem_rd      = rd_q && (state == ISSUE1 || state == ISSUE2);
        bus.o_mem_wr      = !rd_q && (state == ISSUE1 || state == ISSUE2);
        bus.o_mem_refresh = state == REF_ISSUE;
        bus.o_mem_addr    = first ? word_addr : second ? word_addr + ADDR_W'(DATA_BYTES) : '0;
        bus.o_mem_wdata   = rd_q ? '0 : first ? wd2[DW-1:0] : second ? wd2[2*DW-1:DW] : '0;
        bus.o_mem_mask_n  = (!rd_q && first) ? ~be2[DATA_BYTES-1:0] :
                            (!rd_q && second) ? ~be2[2*DATA_BYTES-1:DATA_BYTES] : '1;
    end
    always_ff @(posedge clk or negedge rst_x)
        if (!rst_x) begin
            stall           <= 1'b0;
            rd_q            <= 1'b0;
            split_q         <= 1'b0;
            zext_q          <= 1'b0;
            addr_q          <= '0;
            size_q          <= '0;
            data_q          <= '0;
            w1_q            <= '0;
            bus.o_data      <= '0;
            bus.o_split_cnt <= '0;
            ref_cnt         <= '0;
            ref_pend        <= 1'b0;
        end else begin
            if (accept) begin
                rd_q            <= bus.i_rd_en;
                split_q         <= split_c;
                zext_q          <= bus.i_ctrl[SZW];
                addr_q          <= bus.i_addr;
                size_q          <= size_c;
                data_q          <= bus.i_data;
                bus.o_split_cnt <= bus.o_split_cnt + 32'(split_c);
            end
            stall <= (accept || ref_go) ? 1'b1 : (state == DONE) ? 1'b0 : stall;
            if (state == WAIT1 && !bus.i_mem_busy)
                w1_q <= bus.i_mem_rdata;
            if (rd_q && !bus.i_mem_busy && (state == WAIT2 || (state == WAIT1 && !split_q)))
                bus.o_data <= ext[DW-1:0];
            // Saturate at the threshold so a long stretch without refresh permission cannot wrap.
            ref_cnt <= ref_go ? '0 : (accept && ref_cnt < 32'(REF_INTERVAL)) ? ref_cnt + 32'd1 : ref_cnt;
            // A command landing in the cycle a refresh starts is kept as a new request.
            ref_pend <= REF_EN != 0 && (ref_go ? bus.i_refresh_cmd :
                        (ref_pend || bus.i_refresh_cmd || (bus.i_refresh_en && ref_cnt >= 32'(REF_INTERVAL))));
        end
endmodule
